// File: rtl/gtfmac_axil_cfg_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : gtfmac_axil_cfg_initiator_if
//  Description : AXI4-Lite bus bundle between the GTFMAC config initiator
//                (master) and the S0 port of the GTFMAC AXI crossbar (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface gtfmac_axil_cfg_initiator_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/gtfmac_axil_cfg_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : gtfmac_axil_cfg_initiator
//  Description : AXI4-Lite master. After reset it writes the five GTFMAC MAC
//                config words (CFG8..CFG12), then serves single host
//                read/write commands over a valid/ready cmd/rsp interface.
//                Every bus phase is bounded by a TIMEOUT-cycle watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module gtfmac_axil_cfg_initiator #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] INIT_CFG8  = 32'h0000_0000,
    parameter logic [31:0] INIT_CFG9  = 32'h0000_0002,
    parameter logic [31:0] INIT_CFG10 = 32'h0000_0000,
    parameter logic [31:0] INIT_CFG11 = 32'd64,
    parameter logic [31:0] INIT_CFG12 = 32'd9600,
    parameter int          TIMEOUT    = 1024
) (
    input  wire logic                   m_axi_aclk,
    input  wire logic                   m_axi_aresetn,
    gtfmac_axil_cfg_initiator_if.master m_axi,
    input  wire logic                   cmd_valid,
    output logic                        cmd_ready,
    input  wire logic                   cmd_write,
    input  wire logic [31:0]            cmd_addr,
    input  wire logic [31:0]            cmd_wdata,
    output logic                        rsp_valid,
    input  wire logic                   rsp_ready,
    output logic [31:0]                 rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        init_done,
    output logic                        init_err,
    output logic                        timeout_err
);

    localparam logic [2:0] S_INIT_AW = 3'd0;
    localparam logic [2:0] S_INIT_B  = 3'd1;
    localparam logic [2:0] S_IDLE    = 3'd2;
    localparam logic [2:0] S_WR_AW   = 3'd3;
    localparam logic [2:0] S_WR_B    = 3'd4;
    localparam logic [2:0] S_RD_AR   = 3'd5;
    localparam logic [2:0] S_RD_R    = 3'd6;
    localparam logic [2:0] S_RSP     = 3'd7;

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);
    localparam logic [2:0]  c_last_idx = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  r_idx;
    logic [15:0] r_tcnt;
    logic [31:0] r_awaddr;
    logic        r_awvalid;
    logic [31:0] r_wdata;
    logic        r_wvalid;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_bready;
    logic [31:0] r_araddr;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;
    logic        r_init_done;
    logic        r_init_err;
    logic        r_timeout_err;

    logic        w_init;
    logic        w_counting;
    logic        w_timeout;
    logic        w_aw_ok;
    logic        w_w_ok;
    logic        w_init_step;
    logic [31:0] w_init_addr;
    logic [31:0] w_init_data;

    assign m_axi.awaddr  = r_awaddr;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_bready;
    assign m_axi.araddr  = r_araddr;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_rready;

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign init_done   = r_init_done;
    assign init_err    = r_init_err;
    assign timeout_err = r_timeout_err;

    assign w_init     = (r_state == S_INIT_AW) || (r_state == S_INIT_B);
    assign w_counting = (r_state == S_INIT_AW) || (r_state == S_INIT_B) ||
                        (r_state == S_WR_AW)   || (r_state == S_WR_B)   ||
                        (r_state == S_RD_AR)   || (r_state == S_RD_R);
    assign w_timeout  = w_counting && (r_tcnt == c_tmo_last);

    // A channel counts as accepted if it was accepted earlier or is accepted now
    assign w_aw_ok = r_aw_done | (r_awvalid & m_axi.awready);
    assign w_w_ok  = r_w_done  | (r_wvalid  & m_axi.wready);

    // Init word finished: either its B beat arrived or the watchdog fired
    assign w_init_step = w_init &&
                         (w_timeout || ((r_state == S_INIT_B) && r_bready && m_axi.bvalid));

    assign w_init_addr = BASE_ADDR + {27'd0, r_idx, 2'b00};

    // Init data word selected by the init index
    always_comb begin
        w_init_data = INIT_CFG8;
        case (r_idx)
            3'd1:    w_init_data = INIT_CFG9;
            3'd2:    w_init_data = INIT_CFG10;
            3'd3:    w_init_data = INIT_CFG11;
            3'd4:    w_init_data = INIT_CFG12;
            default: w_init_data = INIT_CFG8;
        endcase
    end

    // Control FSM, AXI channel registers, watchdog and host response
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state       <= S_INIT_AW;
            r_idx         <= 3'd0;
            r_tcnt        <= 16'd0;
            r_awaddr      <= 32'd0;
            r_awvalid     <= 1'b0;
            r_wdata       <= 32'd0;
            r_wvalid      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_bready      <= 1'b0;
            r_araddr      <= 32'd0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_resp    <= 2'b00;
            r_init_done   <= 1'b0;
            r_init_err    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tcnt <= w_counting ? (r_tcnt + 16'd1) : 16'd0;
            if (w_timeout) begin
                // Abandon the phase: drop every valid/ready and report SLVERR
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_aw_done     <= 1'b0;
                r_w_done      <= 1'b0;
                r_tcnt        <= 16'd0;
                r_timeout_err <= 1'b1;
                if (w_init) begin
                    r_init_err <= 1'b1;
                end else begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_resp  <= 2'b10;
                    r_rsp_rdata <= 32'd0;
                    r_state     <= S_RSP;
                end
            end else begin
                case (r_state)
                    S_INIT_AW, S_WR_AW: begin
                        if (!r_awvalid && !r_wvalid && !r_aw_done && !r_w_done) begin
                            // First cycle in the phase: raise AW and W together
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            if (w_init) begin
                                r_awaddr <= w_init_addr;
                                r_wdata  <= w_init_data;
                            end
                        end else begin
                            if (r_awvalid && m_axi.awready) begin
                                r_awvalid <= 1'b0;
                                r_aw_done <= 1'b1;
                            end
                            if (r_wvalid && m_axi.wready) begin
                                r_wvalid <= 1'b0;
                                r_w_done <= 1'b1;
                            end
                            if (w_aw_ok && w_w_ok) begin
                                r_aw_done <= 1'b0;
                                r_w_done  <= 1'b0;
                                r_bready  <= 1'b1;
                                r_tcnt    <= 16'd0;
                                r_state   <= w_init ? S_INIT_B : S_WR_B;
                            end
                        end
                    end
                    S_INIT_B, S_WR_B: begin
                        if (r_bready && m_axi.bvalid) begin
                            r_bready <= 1'b0;
                            r_tcnt   <= 16'd0;
                            if (w_init) begin
                                if (m_axi.bresp != 2'b00) begin
                                    r_init_err <= 1'b1;
                                end
                            end else begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_resp  <= m_axi.bresp;
                                r_rsp_rdata <= 32'd0;
                                r_state     <= S_RSP;
                            end
                        end
                    end
                    S_RD_AR: begin
                        if (!r_arvalid) begin
                            r_arvalid <= 1'b1;
                        end else if (m_axi.arready) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                            r_tcnt    <= 16'd0;
                            r_state   <= S_RD_R;
                        end
                    end
                    S_RD_R: begin
                        if (r_rready && m_axi.rvalid) begin
                            r_rready    <= 1'b0;
                            r_tcnt      <= 16'd0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= m_axi.rdata;
                            r_rsp_resp  <= m_axi.rresp;
                            r_state     <= S_RSP;
                        end
                    end
                    S_RSP: begin
                        if (rsp_ready) begin
                            r_rsp_valid <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                    S_IDLE: begin
                        if (cmd_valid && r_cmd_ready) begin
                            r_cmd_ready <= 1'b0;
                            if (cmd_write) begin
                                r_awaddr <= cmd_addr;
                                r_wdata  <= cmd_wdata;
                                r_state  <= S_WR_AW;
                            end else begin
                                r_araddr <= cmd_addr;
                                r_state  <= S_RD_AR;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            // Advance the init sequence; errors never stop it
            if (w_init_step) begin
                r_tcnt <= 16'd0;
                if (r_idx == c_last_idx) begin
                    r_init_done <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end else begin
                    r_idx   <= r_idx + 3'd1;
                    r_state <= S_INIT_AW;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gtfmac_axil_cfg_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gtfmac_axil_cfg_initiator
//  Description : Directed bench for the GTFMAC config initiator with a small
//                reactive AXI4-Lite slave model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gtfmac_axil_cfg_initiator;

    localparam int c_timeout = 16;
    localparam logic [31:0] c_init [5] = '{32'h0, 32'h2, 32'h0, 32'h40, 32'h2580};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        init_done;
    logic        init_err;
    logic        timeout_err;

    always #5 clk = ~clk;

    gtfmac_axil_cfg_initiator_if m_axi();

    gtfmac_axil_cfg_initiator #(
        .TIMEOUT (c_timeout)
    ) u_dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .m_axi         (m_axi),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .init_done     (init_done),
        .init_err      (init_err),
        .timeout_err   (timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Slave configuration (written by the stimulus process only)
    int          aw_dly = 0;
    int          w_dly = 0;
    int          ar_dly = 0;
    int          r_dly = 0;
    int          b_err_idx = -1;
    bit          ar_never = 1'b0;
    logic [31:0] rd_data = 32'd0;

    // Slave state and logs (written by the slave process only)
    int          aw_cnt, w_cnt, ar_cnt, r_wait;
    bit          r_pend, b_fire, r_fire;
    int          aw_n, w_n, b_n, rsp_n;
    logic [31:0] aw_log [16];
    logic [31:0] w_log [16];
    logic [31:0] ar_last;

    // Slave model: decides readies on the falling edge; a beat is logged when
    // valid and ready are both set going into the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
            m_axi.bvalid = 1'b0;  m_axi.bresp = 2'b00;
            m_axi.rvalid = 1'b0;  m_axi.rresp = 2'b00; m_axi.rdata = 32'd0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_wait = 0;
            r_pend = 1'b0; b_fire = 1'b0; r_fire = 1'b0;
            aw_n = 0; w_n = 0; b_n = 0; rsp_n = 0; ar_last = 32'd0;
        end else begin
            if (b_fire) begin m_axi.bvalid = 1'b0; b_fire = 1'b0; end
            if (r_fire) begin m_axi.rvalid = 1'b0; r_fire = 1'b0; end
            if (!m_axi.bvalid && aw_n > b_n && w_n > b_n) begin
                m_axi.bvalid = 1'b1;
                m_axi.bresp  = (b_n == b_err_idx) ? 2'b10 : 2'b00;
                b_n++;
            end
            if (m_axi.bvalid && m_axi.bready) b_fire = 1'b1;
            if (r_pend) begin
                r_wait++;
                if (r_wait > r_dly) begin
                    m_axi.rvalid = 1'b1; m_axi.rdata = rd_data; m_axi.rresp = 2'b00;
                    r_pend = 1'b0;
                end
            end
            if (m_axi.rvalid && m_axi.rready) r_fire = 1'b1;
            aw_cnt = m_axi.awvalid ? aw_cnt + 1 : 0;
            m_axi.awready = m_axi.awvalid && (aw_cnt > aw_dly);
            if (m_axi.awvalid && m_axi.awready) begin
                if (aw_n < 16) aw_log[aw_n] = m_axi.awaddr;
                aw_n++;
            end
            w_cnt = m_axi.wvalid ? w_cnt + 1 : 0;
            m_axi.wready = m_axi.wvalid && (w_cnt > w_dly);
            if (m_axi.wvalid && m_axi.wready) begin
                if (w_n < 16) w_log[w_n] = m_axi.wdata;
                w_n++;
            end
            ar_cnt = m_axi.arvalid ? ar_cnt + 1 : 0;
            m_axi.arready = m_axi.arvalid && !ar_never && (ar_cnt > ar_dly);
            if (m_axi.arvalid && m_axi.arready) begin
                ar_last = m_axi.araddr; r_pend = 1'b1; r_wait = 0;
            end
            if (rsp_valid && rsp_ready) rsp_n++;
        end
    end

    task automatic wait_init();
        for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
        check("init_done", {31'd0, init_done}, 32'd1);
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
        check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int k;
        int n0;
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_valids", {25'd0, m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready,
                             m_axi.rready, cmd_ready, rsp_valid}, 32'd0);
        check("rst_flags", {29'd0, init_done, init_err, timeout_err}, 32'd0);
        check("rst_wstrb", {28'd0, m_axi.wstrb}, 32'hF);
        check("rst_data", m_axi.awaddr | m_axi.araddr | m_axi.wdata | rsp_rdata, 32'd0);

        // Init sequence, with a host command held off until init completes
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("holdoff_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        wait_init();
        check("init_err_clean", {31'd0, init_err}, 32'd0);
        check("init_aw_count", aw_n, 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("init_addr%0d", i), aw_log[i], 32'(i * 4));
            check($sformatf("init_data%0d", i), w_log[i], c_init[i]);
        end

        // Host write, W accepted 3 cycles before AW
        aw_dly = 3; w_dly = 0;
        send_cmd(1'b1, 32'h4C0, 32'hDEAD_BEEF);
        k = 0;
        for (int i = 0; i < 100 && !rsp_valid; i++) begin
            if (m_axi.awvalid && !m_axi.wvalid) k++;
            @(negedge clk);
        end
        check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr_aw_alone", k, 32'd3);
        check("wr_aw_beats", aw_n, 32'd6);
        check("wr_w_beats", w_n, 32'd6);
        check("wr_addr", aw_log[5], 32'h4C0);
        check("wr_data", w_log[5], 32'hDEAD_BEEF);
        check("wr_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        check("wr_rsp_rdata", rsp_rdata, 32'd0);
        ack_rsp();
        aw_dly = 0;

        // Host read, slow slave, host stalls the response for 4 cycles
        r_dly = 5; rd_data = 32'h1234_5678;
        n0 = rsp_n;
        send_cmd(1'b0, 32'h4C4, 32'd0);
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
        check("rd_addr", ar_last, 32'h4C4);
        for (int i = 0; i < 4; i++) begin
            check("rd_hold_data", rsp_rdata, 32'h1234_5678);
            check("rd_hold_ctl", {29'd0, rsp_valid, rsp_resp}, 32'h4);
            @(negedge clk);
        end
        ack_rsp();
        repeat (3) @(negedge clk);
        check("rd_single_rsp", rsp_n - n0, 32'd1);
        check("rd_rsp_dropped", {31'd0, rsp_valid}, 32'd0);
        r_dly = 0;

        // Read timeout with arready stuck low
        ar_never = 1'b1;
        send_cmd(1'b0, 32'h4C8, 32'd0);
        k = 0;
        for (int i = 0; i < 100 && !rsp_valid; i++) begin
            if (m_axi.arvalid) k++;
            @(negedge clk);
        end
        check("tmo_arvalid_cycles", k, 32'(c_timeout - 1));
        check("tmo_rsp", {29'd0, rsp_valid, rsp_resp}, 32'h6);
        check("tmo_rdata", rsp_rdata, 32'd0);
        check("tmo_flags", {30'd0, timeout_err, init_err}, 32'h2);
        check("tmo_arvalid_low", {31'd0, m_axi.arvalid}, 32'd0);
        ack_rsp();
        check("tmo_back_idle", {31'd0, cmd_ready}, 32'd1);
        ar_never = 1'b0;

        // Reset while a write is in flight
        aw_dly = 20; w_dly = 20;
        send_cmd(1'b1, 32'h4D0, 32'h55);
        repeat (3) @(negedge clk);
        check("mid_valids_high", {30'd0, m_axi.awvalid, m_axi.wvalid}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_valids_async", {30'd0, m_axi.awvalid, m_axi.wvalid}, 32'd0);
        check("mid_no_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("mid_flags_cleared", {29'd0, rsp_valid, timeout_err, init_done}, 32'd0);
        aw_dly = 0; w_dly = 0;
        rst_n = 1'b1;
        wait_init();
        check("restart_aw_count", aw_n, 32'd5);
        check("restart_addr0", aw_log[0], 32'h0);
        check("restart_data0", w_log[0], 32'h0);

        // SLVERR on the CFG10 init write; remaining writes still go out
        @(negedge clk);
        rst_n = 1'b0;
        b_err_idx = 2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        check("err_init_err", {31'd0, init_err}, 32'd1);
        check("err_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("err_aw_count", aw_n, 32'd5);
        check("err_addr3", aw_log[3], 32'hC);
        check("err_addr4", aw_log[4], 32'h10);
        check("err_data4", w_log[4], 32'd9600);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gtfmac_axil_cfg_initiator.md
Name: gtfmac_axil_cfg_initiator

Overview:
- AXI4-Lite master that programs the GTFMAC MAC config block (CFG8..CFG12) and the downstream GTFMAC register space.
- After reset it autonomously writes five init values, then serves single host read/write commands over a valid/ready command/response interface.
- Drives the S0 slave port of the GTFMAC AXI crossbar; the crossbar's shadow ctl_* outputs follow the init writes.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of CFG8; CFG9..CFG12 follow at +0x4 each.
- INIT_CFG8, 32'h0000_0000, init write data for CFG8 (rx/tx data rate).
- INIT_CFG9, 32'h0000_0002, init write data for CFG9 (fcs_ins_enable=1, tx_ignore_fcs=0).
- INIT_CFG10, 32'h0000_0000, init write data for CFG10.
- INIT_CFG11, 32'd64, init write data for CFG11 (rx min packet length).
- INIT_CFG12, 32'd9600, init write data for CFG12 (rx max packet length).
- TIMEOUT, 1024, maximum cycles waited in any single bus phase; range 2..65535.

Ports:
- m_axi_aclk  in  1  clock
- m_axi_aresetn  in  1  asynchronous active-low reset
- m_axi_awaddr/awvalid/awready  out/out/in  32/1/1  AXI-Lite write address channel
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI-Lite write data channel
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI-Lite write response channel
- m_axi_araddr/arvalid/arready  out/out/in  32/1/1  AXI-Lite read address channel
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  AXI-Lite read data channel
- cmd_valid/cmd_ready  in/out  1/1  command handshake
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  absolute byte address
- cmd_wdata  in  32  write data
- rsp_valid/rsp_ready  out/in  1/1  response handshake
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  bresp/rresp; 2'b10 forced on timeout
- init_done  out  1  sticky; set when the init sequence completes
- init_err  out  1  sticky; set on any init write with non-OKAY bresp or timeout
- timeout_err  out  1  sticky; set on any phase timeout

Behaviour:
- Reset: all AXI valid/ready outputs 0, addr/data 0, wstrb 4'hF constant. cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, init_done=0, init_err=0, timeout_err=0. State enters INIT_AW with index 0.
- Reset asserted mid-transaction drops every valid asynchronously. Any in-flight command is lost and no response is issued.
- All outputs are registered.
- States:
  - INIT_AW: issue write for init index i. awaddr=BASE_ADDR+4*i, wdata=INIT_CFG(8+i). Go to INIT_B.
  - INIT_B: wait for bresp. Then i++; after i=4 go to IDLE and set init_done.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the command, set cmd_ready=0, go to WR_AW if cmd_write else RD_AR.
  - WR_AW: awvalid and wvalid rise together the cycle after entry. Each valid drops independently the cycle after its own ready is sampled high; either order or simultaneous acceptance is legal. When both are accepted go to WR_B.
  - WR_B: bready=1. On bvalid capture bresp, go to RSP.
  - RD_AR: arvalid=1 until arready, then RD_R.
  - RD_R: rready=1. On rvalid capture rdata/rresp, go to RSP.
  - RSP: rsp_valid=1, outputs held stable until rsp_ready; then IDLE.
- Init writes reuse the WR_AW/WR_B datapath but skip RSP. Any non-OKAY bresp sets init_err; the sequence continues.
- Timeout:
  - A 16-bit counter clears on every state entry and increments each cycle in WR_AW, WR_B, RD_AR, RD_R.
  - At count == TIMEOUT-1: deassert all AXI valids/readies, set timeout_err, rsp_resp=2'b10, rsp_rdata=0, go to RSP. During init, also set init_err and advance to the next index.
- Only one outstanding transaction at any time; no AXI ID or burst signals.
- A cmd_valid asserted before init_done is held off; cmd_ready stays 0.

Test Plan:
- Release reset, slave always ready with OKAY -> writes 0x0,0x2,0x0,0x40,0x2580 at BASE+0x0..0x10 in order; init_done=1, init_err=0; crossbar ctl_rx_max_packet_len=9600.
- Host write addr 0x4C0, data 0xDEAD_BEEF; wready 3 cycles before awready -> each valid drops after its own ready, exactly one AW and one W beat; rsp_resp=00, rsp_rdata=0.
- Host read addr 0x4C4, slave returns 0x1234_5678 with rresp=00 after 5 cycles; rsp_ready low for 4 cycles -> rsp_rdata/rsp_resp held stable, single response.
- Slave returns bresp=2'b10 on the CFG10 init write -> init_err=1, CFG11/CFG12 writes still issued, init_done=1.
- TIMEOUT=16, arready tied 0 -> arvalid drops after 16 cycles, timeout_err=1, rsp_resp=10, returns to IDLE with cmd_ready=1.
- Reset pulsed while awvalid is high -> awvalid/wvalid low immediately; no rsp_valid; init sequence restarts from CFG8 after release.
